// File: rtl/variable_saturation_st.sv
// variable_saturation_st
// Two-stage streaming scaler: S1 applies a per-mode arithmetic right shift
// (optionally round-half-up), S2 clips the result to a signed OUT_W range.
// Optional feature macro: VARSAT_SAT_COUNT_EN enables the sat_count counter
// of clipped output samples; without it sat_count is tied to zero.
//
// Handshake (both ports, Avalon-ST style):
//   a beat transfers on a rising clk edge where valid && ready are both 1;
//   a source holds data/error/valid/sat_flag unchanged while valid=1 and
//   ready=0; ast_sink_ready is combinational and may depend on
//   ast_source_ready, but never on ast_sink_valid.
module variable_saturation_st #(
    parameter int                      IN_W      = 35,
    parameter int                      OUT_W     = 12,
    parameter int                      NUM_MODES = 4,
    parameter logic [NUM_MODES*6-1:0]  LSB_DROP  = {6'd16, 6'd19, 6'd20, 6'd15},
    parameter int                      ROUND     = 0,
    localparam int                     SEL_W     = $clog2(NUM_MODES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  sel,
    input  logic [IN_W-1:0]   ast_sink_data,
    input  logic [1:0]        ast_sink_error,
    input  logic              ast_sink_valid,
    output logic              ast_sink_ready,
    output logic [OUT_W-1:0]  ast_source_data,
    output logic [1:0]        ast_source_error,
    output logic              ast_source_valid,
    input  logic              ast_source_ready,
    output logic              sat_flag,
    output logic [15:0]       sat_count
);

    // One guard bit above the input width so the rounding add cannot wrap.
    localparam int VW = IN_W + 1;

    // Output clip limits, expressed at the internal value width.
    localparam logic signed [VW-1:0] SAT_MAX =
        {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [VW-1:0] SAT_MIN =
        {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    // Stage registers
    logic                  s1_valid_q;
    logic signed [VW-1:0]  s1_value_q;
    logic [1:0]            s1_error_q;

    logic                  s2_valid_q;
    logic [OUT_W-1:0]      s2_data_q;
    logic [1:0]            s2_error_q;
    logic                  s2_flag_q;

    // Flow control and stage next-state signals
    logic                  advance;
    logic                  s1_open;
    logic                  accept;
    logic [SEL_W-1:0]      mode;
    logic [5:0]            drop;
    logic signed [VW-1:0]  data_ext;
    logic signed [VW-1:0]  half_lsb;
    logic signed [VW-1:0]  round_add;
    logic signed [VW-1:0]  s1_value_d;
    logic                  sat_hi;
    logic                  sat_lo;
    logic [OUT_W-1:0]      s2_data_d;
    logic                  s2_flag_d;

    // S2 moves when it is empty or its sample is being taken downstream;
    // S1 can take a new sample when it is empty or is moving into S2.
    assign advance        = !s2_valid_q || ast_source_ready;
    assign s1_open        = !s1_valid_q || advance;
    assign ast_sink_ready = !reset && s1_open;
    assign accept         = ast_sink_valid && ast_sink_ready;

    // Mode decode: out-of-range selectors fall back to mode 0.
    always_comb begin
        mode = sel;
        if (int'(sel) >= NUM_MODES) begin
            mode = '0;
        end
        drop = LSB_DROP[int'(mode)*6 +: 6];
    end

    // S1 arithmetic: sign-extend, optionally add the bit just below the new
    // LSB at its own weight (round-half-up), then arithmetic shift right.
    always_comb begin
        data_ext  = {ast_sink_data[IN_W-1], ast_sink_data};
        half_lsb  = '0;
        round_add = '0;
        if (ROUND != 0 && drop != 6'd0) begin
            half_lsb = VW'(1) << (drop - 6'd1);
            if ((data_ext & half_lsb) != '0) begin
                round_add = half_lsb;
            end
        end
        s1_value_d = (data_ext + round_add) >>> drop;
    end

    // S2 clip: compare at full width, flag any clipped sample.
    always_comb begin
        sat_hi    = s1_value_q > SAT_MAX;
        sat_lo    = s1_value_q < SAT_MIN;
        s2_data_d = s1_value_q[OUT_W-1:0];
        if (sat_hi) begin
            s2_data_d = OUT_MAX;
        end else if (sat_lo) begin
            s2_data_d = OUT_MIN;
        end
        s2_flag_d = sat_hi || sat_lo;
    end

    // S1 register: captures the scaled value (mode baked in) and error.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_value_q <= '0;
            s1_error_q <= '0;
        end else if (s1_open) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_value_q <= s1_value_d;
                s1_error_q <= ast_sink_error;
            end
        end
    end

    // S2 register: output stage, held while stalled by the sink.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_error_q <= '0;
            s2_flag_q  <= 1'b0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q  <= s2_data_d;
                s2_error_q <= s1_error_q;
                s2_flag_q  <= s2_flag_d;
            end
        end
    end

    assign ast_source_valid = s2_valid_q;
    assign ast_source_data  = s2_data_q;
    assign ast_source_error = s2_error_q;
    assign sat_flag         = s2_flag_q;

`ifdef VARSAT_SAT_COUNT_EN
    logic [15:0] sat_count_q;

    // Count clipped samples as they leave; stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count_q <= '0;
        end else if (s2_valid_q && ast_source_ready && s2_flag_q &&
                     sat_count_q != 16'hFFFF) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end

    assign sat_count = sat_count_q;
`else
    assign sat_count = 16'h0000;
`endif

endmodule

// File: doc/variable_saturation_st.md
VARIABLE_SATURATION_ST -- requirements
Module: variable_saturation_st

Interface
REQ-001 SHALL have parameter IN_W, default 35, input sample width (signed two's complement).
REQ-002 SHALL have parameter OUT_W, default 12, output sample width (signed), OUT_W < IN_W.
REQ-003 SHALL have parameter NUM_MODES, default 4, number of scaling modes (2..16); SEL_W = clog2(NUM_MODES).
REQ-004 SHALL have parameter LSB_DROP, default {6'd16,6'd19,6'd20,6'd15} (mode 3..0), packed 6-bit LSBs-removed per mode; each entry <= IN_W-OUT_W.
REQ-005 SHALL have parameter ROUND, default 0: 0 = truncation, 1 = round-half-up.
REQ-006 clk  input  1  clock, all logic rising-edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 sel  input  SEL_W  scaling mode, sampled with each accepted input.
REQ-009 ast_sink_data  input  IN_W  input sample.
REQ-010 ast_sink_error  input  2  input error, carried with sample.
REQ-011 ast_sink_valid  input  1  input sample valid.
REQ-012 ast_sink_ready  output  1  block can accept input this cycle.
REQ-013 ast_source_data  output  OUT_W  scaled, saturated sample.
REQ-014 ast_source_error  output  2  error aligned with ast_source_data.
REQ-015 ast_source_valid  output  1  output sample valid.
REQ-016 ast_source_ready  input  1  downstream accepts output.
REQ-017 sat_flag  output  1  current output sample was clipped.
REQ-018 sat_count  output  16  clipped-sample counter (see Configuration).

Function
REQ-019 Input SHALL be accepted on cycles where ast_sink_valid && ast_sink_ready.
REQ-020 Pipeline SHALL be two registered stages (S1 scale/round, S2 saturate); an accepted sample SHALL appear on the source two cycles later absent backpressure.
REQ-021 Pipeline SHALL advance when S2 empty or ast_source_ready=1; ast_sink_ready SHALL equal (S1 empty or advance), combinationally, giving full throughput of one sample/cycle.
REQ-022 Output SHALL hold data, error, valid, sat_flag stable while ast_source_valid=1 and ast_source_ready=0.
REQ-023 sel SHALL be registered with its sample; a sel change SHALL never affect samples already in flight.
REQ-024 sel >= NUM_MODES SHALL be treated as mode 0.
REQ-025 S1: d = LSB_DROP[mode]; value = data >>> d (arithmetic); if ROUND=1, add bit (d-1) of data before shift when d>0, computed at IN_W+1 bits (no wrap).
REQ-026 S2: if value > 2^(OUT_W-1)-1 output SHALL be 2^(OUT_W-1)-1; if value < -2^(OUT_W-1) output SHALL be -2^(OUT_W-1); else low OUT_W bits; sat_flag=1 iff clipped.
REQ-027 ast_sink_error SHALL pass through both stages unmodified alongside its sample.
REQ-028 Simultaneous output consumption and input acceptance with pipeline full SHALL lose no sample and duplicate none.

Reset
REQ-029 Reset SHALL clear both stage valid bits; ast_source_valid=0, ast_source_data=0, ast_source_error=0, sat_flag=0, sat_count=0 on the cycle after reset is sampled high.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight samples; ast_sink_ready SHALL be 0 while reset=1.

Configuration
REQ-031 With macro VARSAT_SAT_COUNT_EN defined, sat_count SHALL increment by one per output sample transferred (valid && ready) with sat_flag=1, saturating at 16'hFFFF (no wrap); without it, sat_count SHALL be constant 0 and no counter logic instantiated.

Verification
REQ-032 Default params, sel=0, input 35'h0000_8000 (2^15) -> output 12'h001, latency 2 cycles, sat_flag=0.
REQ-033 sel=1, input 2^34-1 -> output 12'h7FF, sat_flag=1; input -2^34 -> 12'h800, sat_flag=1; with VARSAT_SAT_COUNT_EN sat_count=2.
REQ-034 ROUND=1, sel=0, input 3*2^14 (1.5 LSB) -> 12'h002; ROUND=0 -> 12'h001; input -2^14 ROUND=1 -> 12'h000.
REQ-035 Continuous valid stream of 8 ramp samples with ast_source_ready toggling 1,0,0,1,... -> all 8 outputs in order, none lost/duplicated, outputs stable while stalled.
REQ-036 sel switched 0->3 every cycle across stream -> each output scaled by the mode present at its own acceptance; sel=3 with NUM_MODES=3 -> mode 0 result.
REQ-037 reset pulsed with 2 samples in flight -> ast_source_valid=0 next cycle, neither sample emitted, sat_count=0.
